sys_array_sequencer: RTL and testbench
======================================

SYS_ARRAY_SEQUENCER -- requirements
Module: sys_array_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand width; result elements are 2*DATA_WIDTH bits.
REQ-002 Parameter ARRAY_W_W, default 2: result rows.
REQ-003 Parameter ARRAY_A_L, default 2: result columns.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: maximum wait per handshake phase (at least 2).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 go  in  1  start-run request, sampled only in IDLE.
REQ-008 abort  in  1  return to IDLE from any state.
REQ-009 fetch_ready  in  1  fetcher parameters loaded and fetcher idle.
REQ-010 fetch_out_ready  in  1  fetcher result matrix valid.
REQ-011 fetch_result  in  ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH  result matrix, row-major; element [0][0] in the MSBs.
REQ-012 load_params  out  1  one-cycle load pulse to the fetcher.
REQ-013 start_comp  out  1  one-cycle compute pulse to the fetcher.
REQ-014 res_valid  out  1  res_data holds a valid element.
REQ-015 res_ready  in  1  downstream accepts the element.
REQ-016 res_data  out  2*DATA_WIDTH  current element.
REQ-017 res_row / res_col  out  clog2 widths, minimum 1  index of the current element.
REQ-018 res_last  out  1  current element is [ARRAY_W_W-1][ARRAY_A_L-1].
REQ-019 busy  out  1  high in every state except IDLE and ERROR.
REQ-020 done  out  1  one-cycle pulse when the run completes.
REQ-021 error  out  1  timeout flag; held until abort.

Function
REQ-022 States SHALL be IDLE, LOAD, WAIT_LOAD, START, ARM, WAIT_COMP, DRAIN, DONE, ERROR, with the transitions given in REQ-023 to REQ-032.
REQ-023 IDLE & go & !abort -> LOAD; go is ignored in every other state.
REQ-024 LOAD SHALL assert load_params for exactly one cycle, then -> WAIT_LOAD.
REQ-025 WAIT_LOAD: fetch_ready=1 -> START.
REQ-026 START SHALL assert start_comp for exactly one cycle, then -> ARM.
REQ-027 ARM: wait for fetch_out_ready=0, so a stale result is not taken; then -> WAIT_COMP.
REQ-028 WAIT_COMP: fetch_out_ready=1 -> DRAIN; on that same edge, capture fetch_result into an internal snapshot register.
REQ-029 Timeout counter: cleared on entry to WAIT_LOAD, ARM and WAIT_COMP; increments each cycle in those states; on reaching TIMEOUT_CYCLES -> ERROR with error=1.
REQ-030 DRAIN: present snapshot elements in row-major order starting at [0][0]; res_valid=1; advance only on res_valid & res_ready; column wraps to 0 and row increments at ARRAY_A_L-1.
REQ-031 DRAIN: res_data, res_row and res_col SHALL stay stable while res_valid & !res_ready; snapshot changes to fetch_result during DRAIN are ignored.
REQ-032 Acceptance of the res_last element -> DONE; DONE pulses done for one cycle, then -> IDLE.
REQ-033 abort SHALL take priority over every other transition, including go in IDLE: next state IDLE; error, res_valid and the counters cleared; no load_params or start_comp pulse that cycle.
REQ-034 load_params and start_comp SHALL be registered outputs and never both high in the same cycle.
REQ-035 For a 1x1 result, the single element SHALL have res_last=1.

Reset
REQ-036 reset_n=0 SHALL asynchronously force IDLE and drive load_params, start_comp, res_valid, res_last, busy, done and error to 0, and res_data, res_row, res_col, the timeout counter and the snapshot to 0.
REQ-037 Reset asserted mid-run SHALL abandon the run with no further pulses; after release the block waits in IDLE for a new go.

Verification
REQ-038 Nominal 2x2 run: go pulse; fetch_ready 3 cycles after load_params; fetch_out_ready 0, then 1 after 10 cycles with result {1,2,3,4}; res_ready=1 -> exactly one load_params and one start_comp pulse, elements 1,2,3,4 at (0,0),(0,1),(1,0),(1,1), res_last on 4, done one cycle later.
REQ-039 Backpressure: res_ready low for 5 cycles on element 2 -> res_data=2, row 0, col 1 held stable; no element lost or duplicated.
REQ-040 Stale result: fetch_out_ready held 1 through START -> block stays in ARM until it drops, and never drains early.
REQ-041 Timeout with TIMEOUT_CYCLES=8: fetch_ready never asserted -> error=1 and busy=0 after 8 WAIT_LOAD cycles; go ignored until abort clears error.
REQ-042 Abort during DRAIN after 2 accepted elements -> IDLE next cycle, res_valid=0, no done; a following go runs cleanly from [0][0].
REQ-043 reset_n pulsed low during WAIT_COMP -> all outputs 0 immediately; no start_comp after release.

Source files
------------

// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer
//   Sequences one run of an external systolic-array fetcher: pulses
//   load_params, waits for the fetcher to report ready, pulses start_comp,
//   waits for a fresh result matrix, snapshots it, and streams the elements
//   out in row-major order over a valid/ready port.  Each handshake wait is
//   bounded by TIMEOUT_CYCLES; expiry parks the block in ERROR until abort.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   go, abort            run request (IDLE only), unconditional return to IDLE
//   fetch_ready          fetcher parameters loaded and fetcher idle
//   fetch_out_ready      fetcher result matrix valid
//   fetch_result         result matrix, row-major, element [0][0] in the MSBs
//   load_params          one-cycle load pulse to the fetcher
//   start_comp           one-cycle compute pulse to the fetcher
//   res_valid/res_ready  element stream handshake
//   res_data             current element
//   res_row/res_col      index of the current element
//   res_last             current element is the final one
//   busy, done, error    status
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for go
// LOAD      | load_params high for one cycle
// WAIT_LOAD | waiting for fetch_ready (timed)
// START     | start_comp high for one cycle
// ARM       | waiting for fetch_out_ready to drop, rejects stale result (timed)
// WAIT_COMP | waiting for fetch_out_ready, snapshot on accept (timed)
// DRAIN     | streaming snapshot elements
// DONE      | done high for one cycle
// ERROR     | handshake timeout, error held until abort

module sys_array_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ARRAY_W_W      = 2,
    parameter int ARRAY_A_L      = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ROW_W = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1,
    localparam int COL_W = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      go,
    input  logic                                      abort,
    input  logic                                      fetch_ready,
    input  logic                                      fetch_out_ready,
    input  logic [ARRAY_W_W*ARRAY_A_L*2*DATA_WIDTH-1:0] fetch_result,
    output logic                                      load_params,
    output logic                                      start_comp,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [2*DATA_WIDTH-1:0]                   res_data,
    output logic [ROW_W-1:0]                          res_row,
    output logic [COL_W-1:0]                          res_col,
    output logic                                      res_last,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error
);

    localparam int EL_W  = 2 * DATA_WIDTH;
    localparam int N_EL  = ARRAY_W_W * ARRAY_A_L;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_WAIT_LOAD = 4'd2;
    localparam logic [3:0] S_START     = 4'd3;
    localparam logic [3:0] S_ARM       = 4'd4;
    localparam logic [3:0] S_WAIT_COMP = 4'd5;
    localparam logic [3:0] S_DRAIN     = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    logic [3:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [N_EL*EL_W-1:0] snap_q, snap_d;
    logic                 load_q, start_q;
    logic                 timed_out;
    logic                 at_last;
    logic                 col_wrap;
    logic [EL_W-1:0]      elem_sel;

    // Expiry is detected on the last counted cycle so the wait lasts
    // exactly TIMEOUT_CYCLES cycles before ERROR is entered.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign col_wrap  = (col_q == COL_W'(ARRAY_A_L - 1));
    assign at_last   = (row_q == ROW_W'(ARRAY_W_W - 1)) && col_wrap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_WAIT_LOAD;
                cnt_d   = '0;
            end
            S_WAIT_LOAD: begin
                if (fetch_ready)    state_d = S_START;
                else if (timed_out) state_d = S_ERROR;
                else                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_START: begin
                state_d = S_ARM;
                cnt_d   = '0;
            end
            S_ARM: begin
                if (!fetch_out_ready) begin
                    state_d = S_WAIT_COMP;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_COMP: begin
                if (fetch_out_ready) begin
                    state_d = S_DRAIN;
                    snap_d  = fetch_result;
                    row_d   = '0;
                    col_d   = '0;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (res_ready) begin
                    if (at_last) begin
                        state_d = S_DONE;
                    end else if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            load_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            // Pulses are flopped from the next state so they line up with
            // the LOAD/START cycle and can never coincide.
            load_q  <= (state_d == S_LOAD);
            start_q <= (state_d == S_START);
        end
    end

    // Element [0][0] sits in the most significant slot of the snapshot.
    always_comb begin
        elem_sel = '0;
        for (int r = 0; r < ARRAY_W_W; r++) begin
            for (int c = 0; c < ARRAY_A_L; c++) begin
                if (row_q == ROW_W'(r) && col_q == COL_W'(c))
                    elem_sel = snap_q[(N_EL - 1 - (r * ARRAY_A_L + c)) * EL_W +: EL_W];
            end
        end
    end

    assign load_params = load_q;
    assign start_comp  = start_q;
    assign res_valid   = (state_q == S_DRAIN);
    assign res_last    = (state_q == S_DRAIN) && at_last;
    assign res_data    = elem_sel;
    assign res_row     = row_q;
    assign res_col     = col_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);

endmodule

// File: tb/tb_sys_array_sequencer.sv
module tb_sys_array_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0, abort = 1'b0, fetch_ready = 1'b0, fetch_out_ready = 1'b0;
    logic [63:0] fetch_result = '0;
    logic        res_ready = 1'b0;
    logic        load_params, start_comp, res_valid, res_last, busy, done, error;
    logic [15:0] res_data;
    logic        res_row, res_col;

    logic        to_go = 1'b0, to_abort = 1'b0;
    logic        to_load, to_start, to_valid, to_last, to_busy, to_done, to_error;
    logic [15:0] to_data;
    logic        to_row, to_col;

    always #5 clk = ~clk;

    sys_array_sequencer dut (
        .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
        .fetch_ready(fetch_ready), .fetch_out_ready(fetch_out_ready),
        .fetch_result(fetch_result), .load_params(load_params),
        .start_comp(start_comp), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_col(res_col),
        .res_last(res_last), .busy(busy), .done(done), .error(error)
    );

    sys_array_sequencer #(.TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .reset_n(reset_n), .go(to_go), .abort(to_abort),
        .fetch_ready(1'b0), .fetch_out_ready(1'b0),
        .fetch_result(64'h0), .load_params(to_load),
        .start_comp(to_start), .res_valid(to_valid), .res_ready(1'b0),
        .res_data(to_data), .res_row(to_row), .res_col(to_col),
        .res_last(to_last), .busy(to_busy), .done(to_done), .error(to_error)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        r;
        logic        c;
        logic        last;
    } exp_t;

    typedef struct {
        int          rdy_dly;
        int          stale;
        int          comp_dly;
        logic [63:0] res;
        logic [7:0]  rmask;
        int          hold;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_load = 0, n_start = 0, n_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops, pulse counting, stall stability.
    logic        prev_stall = 1'b0, prev_last_acc = 1'b0;
    logic [15:0] prev_data;
    logic        prev_row, prev_col;
    always @(negedge clk) begin
        exp_t e;
        if (load_params) n_load++;
        if (start_comp)  n_start++;
        if (done)        n_done++;
        if (load_params || start_comp) chk("pulse_exclusive", load_params && start_comp, 0);
        if (prev_last_acc) chk("done_after_last", done, 1);
        if (prev_stall && res_valid) begin
            chk("stall_data", res_data, prev_data);
            chk("stall_row", res_row, prev_row);
            chk("stall_col", res_col, prev_col);
        end
        if (res_valid && res_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_element: got %0h with no expected entry", res_data);
            end else begin
                e = sbq.pop_front();
                chk("elem_data", res_data, e.d);
                chk("elem_row", res_row, e.r);
                chk("elem_col", res_col, e.c);
                chk("elem_last", res_last, e.last);
            end
        end
        prev_last_acc = res_valid && res_ready && res_last && !abort;
        prev_stall    = res_valid && !res_ready;
        prev_data     = res_data;
        prev_row      = res_row;
        prev_col      = res_col;
    end

    task automatic wait_for(input int which, input int lim, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            case (which)
                0:       seen = load_params;
                1:       seen = start_comp;
                default: seen = done;
            endcase
        end
    endtask

    task automatic push_exp(input logic [63:0] res);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.d    = res[63-16*i -: 16];
            e.r    = 1'(i / 2);
            e.c    = 1'(i % 2);
            e.last = (i == 3);
            sbq.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int l0, s0, d0, hc;
        bit seen;
        l0 = n_load; s0 = n_start; d0 = n_done; hc = 0;
        fetch_out_ready = (v.stale > 0);
        fetch_result    = ~v.res;
        res_ready       = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_for(0, 10, seen);
        chk({nm, "_load_seen"}, seen, 1);
        repeat (v.rdy_dly) @(posedge clk);
        #1 fetch_ready = 1'b1;
        wait_for(1, 20, seen);
        chk({nm, "_start_seen"}, seen, 1);
        @(posedge clk); #1 fetch_ready = 1'b0;
        if (v.stale > 0) begin
            for (int i = 0; i < v.stale; i++) begin
                @(negedge clk);
                chk({nm, "_stale_no_drain"}, res_valid, 0);
                chk({nm, "_stale_busy"}, busy, 1);
            end
            @(posedge clk); #1 fetch_out_ready = 1'b0;
        end
        repeat (v.comp_dly) @(posedge clk);
        #1 fetch_result = v.res;
        fetch_out_ready = 1'b1;
        push_exp(v.res);
        @(posedge clk); #1 fetch_out_ready = 1'b0;
        fetch_result = ~v.res;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (hc < v.hold && res_valid && res_row == 1'b0 && res_col == 1'b1) begin
                res_ready = 1'b0;
                hc++;
            end else begin
                res_ready = v.rmask[k % 8];
            end
            @(negedge clk);
            if (v.hold > 0 && !res_ready && res_valid && res_row == 1'b0 && res_col == 1'b1)
                chk({nm, "_bp_data"}, res_data, v.res[47:32]);
            seen = done;
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
        res_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, done, 0);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_sb_empty"}, sbq.size(), 0);
        chk({nm, "_n_load"}, n_load - l0, 1);
        chk({nm, "_n_start"}, n_start - s0, 1);
        chk({nm, "_n_done"}, n_done - d0, 1);
    endtask

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int l0, s0, d0;

        vecs[0] = '{rdy_dly:3, stale:0, comp_dly:10, res:64'h0001_0002_0003_0004, rmask:8'hFF, hold:0};
        vecs[1] = '{rdy_dly:1, stale:0, comp_dly:2,  res:64'h0001_0002_0003_0004, rmask:8'hFF, hold:5};
        vecs[2] = '{rdy_dly:0, stale:4, comp_dly:3,  res:64'hFFFF_0000_8001_7FFE, rmask:8'hA6, hold:0};
        vecs[3] = '{rdy_dly:5, stale:0, comp_dly:1,  res:64'h1234_ABCD_00FF_FF00, rmask:8'h5B, hold:2};

        #1;
        chk("rst_load", load_params, 0);
        chk("rst_start", start_comp, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_data", res_data, 0);
        chk("rst_rowcol", {res_row, res_col}, 0);
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort in DRAIN after two accepted elements.
        d0 = n_done;
        fetch_out_ready = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_for(0, 10, seen);
        chk("abort_load_seen", seen, 1);
        @(posedge clk); #1 fetch_ready = 1'b1;
        wait_for(1, 20, seen);
        chk("abort_start_seen", seen, 1);
        @(posedge clk); #1 fetch_ready = 1'b0;
        @(posedge clk); #1 fetch_result = 64'h00A0_00B0_00C0_00D0;
        fetch_out_ready = 1'b1;
        res_ready = 1'b1;
        push_exp(64'h00A0_00B0_00C0_00D0);
        @(posedge clk); #1 fetch_out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 abort = 1'b1;
        res_ready = 1'b0;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rowcol", {res_row, res_col}, 0);
        chk("abort_left", sbq.size(), 2);
        sbq.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        run_vec(vecs[0], "after_abort");

        // Timeout on the short-timeout instance.
        @(posedge clk); #1 to_go = 1'b1;
        @(posedge clk); #1 to_go = 1'b0;
        @(negedge clk);
        chk("to_load", to_load, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_wait_busy", to_busy, 1);
            chk("to_wait_noerr", to_error, 0);
        end
        @(negedge clk);
        chk("to_error", to_error, 1);
        chk("to_busy_off", to_busy, 0);
        @(posedge clk); #1 to_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_go_ignored", to_load, 0);
            chk("to_error_held", to_error, 1);
        end
        @(posedge clk); #1 to_go = 1'b0;
        to_abort = 1'b1;
        @(posedge clk); #1 to_abort = 1'b0;
        @(negedge clk);
        chk("to_abort_clear", to_error, 0);
        chk("to_abort_idle", to_busy, 0);
        @(posedge clk); #1 to_go = 1'b1;
        to_abort = 1'b1;
        @(posedge clk); #1 to_go = 1'b0;
        to_abort = 1'b0;
        @(negedge clk);
        chk("go_abort_noload", to_load, 0);
        chk("go_abort_idle", to_busy, 0);

        // Reset asserted during WAIT_COMP.
        fetch_out_ready = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_for(0, 10, seen);
        @(posedge clk); #1 fetch_ready = 1'b1;
        wait_for(1, 20, seen);
        chk("rstrun_start_seen", seen, 1);
        @(posedge clk); #1 fetch_ready = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", {load_params, start_comp, done, error}, 0);
        chk("midrst_valid", {res_valid, res_last}, 0);
        chk("midrst_data", res_data, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        s0 = n_start; l0 = n_load;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        chk("postrst_no_start", n_start - s0, 0);
        chk("postrst_no_load", n_load - l0, 0);
        chk("postrst_idle", busy, 0);
        run_vec(vecs[3], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
